// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU that processes one operand bit per clock, LSB first.
// It uses one add/sub/logic slice and a registered carry/borrow.
// Optional build macro SERIAL_ALU_FLAGS_EN enables the registered zero/ovf flags.
// When the macro is undefined, the zero and ovf outputs are tied to 0.
//
// Handshake: start is accepted on any rising edge where busy=0 (IDLE or DONE).
// busy is high from the accept edge until the edge that raises done.
// done is a one-cycle pulse, and y/c_out/b_out/zero/ovf are updated on that same edge.
// start seen while busy=1 is dropped; nothing is queued.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             b_in,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;     // bits already produced, collected from the top down
    logic [2:0]       op;
    logic             cb;         // carry (ADD) or borrow (SUB) into the current bit

    logic             accept;
    logic             last;
    logic             bit_a;
    logic             bit_b;
    logic             bit_y;
    logic             cb_next;
    logic [WIDTH-1:0] result_full;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST_BIT);
    assign bit_a  = a_sr[0];
    assign bit_b  = b_sr[0];

    // The next result value, including the bit being computed now (LSB-first shift right).
    assign result_full = {bit_y, res_sr};

    // busy decodes the state register only, so it has no path from the inputs.
    assign busy = (state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE/DONE accept a new start; RUN leaves after the last bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST_BIT) state_next = DONE;
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One-bit slice: add/sub with a carry/borrow chain, or a bitwise logic op
    always_comb begin
        bit_y   = 1'b0;
        cb_next = 1'b0;
        case (op)
            OP_ADD: begin
                bit_y   = bit_a ^ bit_b ^ cb;
                cb_next = (bit_a & bit_b) | (bit_b & cb) | (cb & bit_a);
            end
            OP_SUB: begin
                bit_y   = bit_a ^ bit_b ^ cb;
                cb_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb);
            end
            OP_AND: bit_y = bit_a & bit_b;
            OP_NOR: bit_y = ~(bit_a | bit_b);
            OP_XOR: bit_y = bit_a ^ bit_b;
            default: begin
                bit_y   = 1'b0;
                cb_next = 1'b0;
            end
        endcase
    end

    // Operand capture, serial shifting and the result/carry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op     <= '0;
            cb     <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            c_out  <= 1'b0;
            b_out  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                op     <= sel;
                cnt    <= '0;
                res_sr <= '0;
                if (sel == OP_ADD) begin
                    cb <= c_in;
                end else if (sel == OP_SUB) begin
                    cb <= b_in;
                end else begin
                    cb <= 1'b0;
                end
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr <= result_full[WIDTH-1:1];
                cb     <= cb_next;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    y     <= result_full;
                    c_out <= (op == OP_ADD) && cb_next;
                    b_out <= (op == OP_SUB) && cb_next;
                end
            end
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic ovf_next;

    // Signed overflow, evaluated on the MSB step (cb is the carry/borrow into the MSB)
    always_comb begin
        ovf_next = 1'b0;
        case (op)
            OP_ADD:  ovf_next = cb ^ cb_next;
            OP_SUB:  ovf_next = (bit_a ^ bit_b) & (bit_a ^ bit_y);
            default: ovf_next = 1'b0;
        endcase
    end

    // Flag registers, updated together with y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last) begin
            zero <= (result_full == '0);
            ovf  <= ovf_next;
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Directed testbench for serial_alu (WIDTH=8).
// Expected zero/ovf values follow SERIAL_ALU_FLAGS_EN; they are forced to 0 when the flags are compiled out.
module tb_serial_alu;

    localparam int W = 8;

`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         b_in;
    logic [2:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         c_out;
    logic         b_out;
    logic         zero;
    logic         ovf;

    int tests_run;
    int tests_failed;

    serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .b_in  (b_in),
        .sel   (sel),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .c_out (c_out),
        .b_out (b_out),
        .zero  (zero),
        .ovf   (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single comparison point
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request at the current negedge and let the next posedge accept it.
    // The operands are then scrambled to show they are not re-sampled.
    task automatic launch(input string tag, input logic [2:0] op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic ci, input logic bi);
        start = 1'b1;
        sel   = op;
        a     = va;
        b     = vb;
        c_in  = ci;
        b_in  = bi;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom_range(0, 255));
        b     = W'($urandom_range(0, 255));
        c_in  = 1'(~ci);
        b_in  = 1'(~bi);
        sel   = 3'($urandom_range(0, 7));
        check({tag, "_busy_acc"}, 64'(busy), 64'd1);
    endtask

    // Wait (bounded) for done, then check latency and all result outputs.
    // If pulse_at > 0, a stray start is pulsed at that cycle and must be ignored.
    task automatic await_done(input string tag, input logic [W-1:0] ey, input logic ec,
                              input logic eb, input logic ez, input logic eo, input int pulse_at);
        int lat;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (pulse_at > 0 && lat == pulse_at) begin
                start = 1'b1;
                sel   = 3'b000;
                a     = 8'hFF;
                b     = 8'hFF;
                c_in  = 1'b1;
            end else if (pulse_at > 0 && lat == pulse_at + 1) begin
                start = 1'b0;
                check({tag, "_busy_ign"}, 64'(busy), 64'd1);
            end
        end
        check({tag, "_lat"},   64'(lat),   64'd8);
        check({tag, "_y"},     64'(y),     64'(ey));
        check({tag, "_c_out"}, 64'(c_out), 64'(ec));
        check({tag, "_b_out"}, 64'(b_out), 64'(eb));
        check({tag, "_zero"},  64'(zero),  64'(ez & FLAGS));
        check({tag, "_ovf"},   64'(ovf),   64'(eo & FLAGS));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic ci, input logic bi,
                          input logic [W-1:0] ey, input logic ec, input logic eb,
                          input logic ez, input logic eo, input int pulse_at);
        launch(tag, op, va, vb, ci, bi);
        await_done(tag, ey, ec, eb, ez, eo, pulse_at);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        b_in  = 1'b0;
        sel   = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_y",    64'(y),    64'd0);
        check("rst_flags", 64'({c_out, b_out, zero, ovf}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      tag     sel     a      b    ci  bi   y    c  b  z  o  pulse
        run_op("add1", 3'b000, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 0, 0, 1, 0);
        run_op("sub1", 3'b001, 8'h00, 8'h01, 0, 0, 8'hFF, 0, 1, 0, 0, 0);
        run_op("sub2", 3'b001, 8'h05, 8'h05, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        run_op("sub3", 3'b001, 8'h10, 8'h01, 0, 1, 8'h0E, 0, 0, 0, 0, 0);
        run_op("sub4", 3'b001, 8'h80, 8'h01, 0, 0, 8'h7F, 0, 0, 0, 1, 0);
        run_op("nor1", 3'b011, 8'h0F, 8'h30, 0, 0, 8'hC0, 0, 0, 0, 0, 0);
        run_op("xor1", 3'b111, 8'hAA, 8'hFF, 0, 0, 8'h55, 0, 0, 0, 0, 0);
        run_op("and1", 3'b010, 8'hF0, 8'h3C, 0, 0, 8'h30, 0, 0, 0, 0, 0);
        run_op("nop5", 3'b101, 8'hFF, 8'hFF, 1, 1, 8'h00, 0, 0, 1, 0, 0);
        run_op("ign",  3'b000, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0, 0, 3);

        // back-to-back: start presented during the done cycle
        launch("b2b1", 3'b000, 8'h01, 8'h02, 0, 0);
        await_done("b2b1", 8'h03, 0, 0, 0, 0, 0);
        launch("b2b2", 3'b001, 8'h09, 8'h04, 0, 0);
        check("b2b2_done_low", 64'(done), 64'd0);
        await_done("b2b2", 8'h05, 0, 0, 0, 0, 0);
        @(negedge clk);

        // reset in the middle of a run; y currently holds 8'h05
        launch("rst_mid", 3'b000, 8'hFF, 8'hFF, 1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstm_busy", 64'(busy), 64'd0);
        check("rstm_done", 64'(done), 64'd0);
        check("rstm_y",    64'(y),    64'd0);
        check("rstm_flags", 64'({c_out, b_out, zero, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post", 3'b000, 8'hFF, 8'h01, 1, 0, 8'h01, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
